hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core: resolves RAW hazards (forward selects, load-use and
//  branch-compare stalls), sequences the iterative mult/div unit (MDU) and holds the pipe on data-memory wait.
//  Sits beside the control unit. Drives stall/flush enables of the F/D/E/M pipeline registers and the MDU step enable.
// PARAMETERS
//  MULT_CYCLES  32  cycles an MDU multiply occupies (>=1)
//  DIV_CYCLES   33  cycles an MDU divide occupies (>=1)
//  CNT_W        6   MDU cycle-counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk          in   1   core clock
//  reset        in   1   synchronous, active-high reset
//  RsD, RtD     in   5   source regs in Decode
//  RsE, RtE     in   5   source regs in Execute
//  WriteRegE/M/W in  5   destination reg per stage
//  RegWriteE/M/W in  1   stage writes register file
//  MemToRegE/M  in   1   stage holds a load
//  BranchD      in   1   branch compare in Decode
//  MduStartE    in   1   mult/div issued in Execute
//  MduDivE      in   1   1=divide, 0=multiply (valid with MduStartE)
//  HiLoReadD    in   1   mfhi/mflo in Decode
//  MemReqM      in   1   load/store access in Memory
//  MemReadyM    in   1   data memory completes access this cycle
//  StallF, StallD out 1  hold PC / IF-ID register
//  StallE, StallM out 1  hold ID-EX / EX-MEM register
//  FlushE, FlushW out 1  insert bubble into ID-EX / MEM-WB register
//  ForwardAD, ForwardBD out 1  Decode compare operand from M stage
//  ForwardAE, ForwardBE out 2  ALU operand: 00 regfile, 01 W result, 10 M ALU result
//  MduStep      out  1   advance MDU one iteration
//  MduBusy      out  1   MDU state not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, counter=0; every output 0 (except combinational forward selects, which follow inputs).
//  Forwarding (combinational): ForwardAE=10 if RsE!=0 & RegWriteM & WriteRegM==RsE; else 01 if RsE!=0 & RegWriteW
//   & WriteRegW==RsE; else 00. Same for B/RtE. ForwardAD=RsD!=0 & RegWriteM & WriteRegM==RsD; B likewise. M beats W.
//  lwstall = MemToRegE & (RtE==RsD | RtE==RtD).
//  brstall = BranchD & ((RegWriteE & WriteRegE in {RsD,RtD}) | (MemToRegM & WriteRegM in {RsD,RtD})); $0 never matches.
//  hlstall = HiLoReadD & (MduBusy | MduStartE).
//  FSM states IDLE, MDU_RUN, MEM_WAIT:
//   IDLE->MDU_RUN on MduStartE: counter loads (MduDivE?DIV_CYCLES:MULT_CYCLES)-1; MduStep=1 that cycle.
//   MDU_RUN: MduStep=1 each cycle, counter decrements; counter==0 -> IDLE (last step cycle). Pipe keeps running;
//    only hlstall or a second MduStartE stalls. Second MduStartE while busy: StallF/D/E=1, FlushE=0, until IDLE.
//   Any state, MemReqM & !MemReadyM: enter/stay MEM_WAIT: StallF/D/E/M=1, FlushW=1; MDU keeps stepping
//    (counter saved as MDU state; MEM_WAIT returns to MDU_RUN if counter nonzero else IDLE on MemReadyM).
//   MemReadyM in same cycle as MemReqM: no wait state, zero stall.
//  Data hazard stall (lwstall|brstall|hlstall, not in MEM_WAIT): StallF=StallD=FlushE=1.
//  MEM_WAIT dominates data stalls; FlushE never asserted while StallE=1.
//  Latency: stall outputs combinational from current state/inputs; state registered.
//  Reset mid-MDU or mid-wait: returns to IDLE next edge, MduBusy=0, no stall.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs StallCycles[31:0] and MduCycles[31:0]; StallCycles increments each cycle
//   StallF=1, MduCycles each cycle MduBusy=1; both wrap at 2^32, cleared by reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package: FSM state encoding, forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
//  One sub-module: forward_unit (pure combinational forward selects); FSM, counter, stall logic in top.
// TESTING
//  add $3 in M, add $4,$3 in E: ForwardAE=10; same writer only in W -> 01; writer reg $0 -> 00.
//  lw $2 in E, add using $2 in D: one cycle StallF=StallD=FlushE=1, then ForwardAE=01 next cycle.
//  beq $5 with $5 written in E: StallD 1 cycle; writer now in M: ForwardAD=1, no stall.
//  div in E, mfhi next: MduBusy 33 cycles, StallD held until IDLE, mfhi proceeds cycle after.
//  sw in M, MemReadyM low 3 cycles: StallF/D/E/M=1, FlushW=1 for 3 cycles; concurrent MDU counter still decrements.
//  reset asserted mid-multiply (counter=10): next cycle MduBusy=0, all stalls 0; perf counters 0 if enabled.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
// hazard_sequencer_pkg
//   Shared types for the pipeline sequencer: FSM state encoding, forward
//   select encodings, and a register-match helper used by the hazard logic.
//   Optional feature macro used by the top: HAZARD_PERF_CNT_EN.
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MDU_RUN  = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // A writer matches a source only if it writes and is not $0.
  function automatic logic reg_hit(input logic we, input logic [4:0] wr,
                                   input logic [4:0] src);
    return we && (wr != '0) && (wr == src);
  endfunction

endpackage

// File: rtl/hazard_sequencer_forward_unit.sv
// forward_unit
//   Pure combinational forwarding selects.
//   Ports:
//     rs_d_i, rt_d_i        Decode source registers
//     rs_e_i, rt_e_i        Execute source registers
//     write_reg_m_i/w_i     destination register in Memory / Writeback
//     reg_write_m_i/w_i     stage writes the register file
//     fwd_a_d_o, fwd_b_d_o  Decode compare operand taken from M stage
//     fwd_a_e_o, fwd_b_e_o  ALU operand select (FWD_RF / FWD_WB / FWD_MEM)
//   M-stage result has priority over W-stage result.
module forward_unit
  import hazard_sequencer_pkg::*;
(
  input  logic [4:0] rs_d_i,
  input  logic [4:0] rt_d_i,
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rt_e_i,
  input  logic [4:0] write_reg_m_i,
  input  logic [4:0] write_reg_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic       fwd_a_d_o,
  output logic       fwd_b_d_o,
  output logic [1:0] fwd_a_e_o,
  output logic [1:0] fwd_b_e_o
);

  fwd_sel_e sel_a, sel_b;

  always_comb begin
    sel_a = FWD_RF;
    if (reg_hit(reg_write_m_i, write_reg_m_i, rs_e_i))      sel_a = FWD_MEM;
    else if (reg_hit(reg_write_w_i, write_reg_w_i, rs_e_i)) sel_a = FWD_WB;

    sel_b = FWD_RF;
    if (reg_hit(reg_write_m_i, write_reg_m_i, rt_e_i))      sel_b = FWD_MEM;
    else if (reg_hit(reg_write_w_i, write_reg_w_i, rt_e_i)) sel_b = FWD_WB;
  end

  assign fwd_a_e_o = sel_a;
  assign fwd_b_e_o = sel_b;
  assign fwd_a_d_o = reg_hit(reg_write_m_i, write_reg_m_i, rs_d_i);
  assign fwd_b_d_o = reg_hit(reg_write_m_i, write_reg_m_i, rt_d_i);

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline sequencer for the 5-stage MIPS core. Resolves RAW hazards
//   (forward selects, load-use / branch-compare / hi-lo stalls), sequences the
//   iterative mult/div unit and holds the pipe while data memory is not ready.
//   Ports:
//     clk, reset                 core clock, synchronous active-high reset
//     RsD/RtD, RsE/RtE           source registers in Decode / Execute
//     WriteRegE/M/W, RegWriteE/M/W  destination register and write enable
//     MemToRegE/M                stage holds a load
//     BranchD, HiLoReadD         branch compare / mfhi-mflo in Decode
//     MduStartE, MduDivE         mult/div issue in Execute, 1 = divide
//     MemReqM, MemReadyM         data-memory access and completion
//     StallF/D/E/M, FlushE/W     pipeline register hold / bubble enables
//     ForwardAD/BD, ForwardAE/BE forward selects
//     MduStep, MduBusy           MDU iteration enable, MDU active
//   Macro HAZARD_PERF_CNT_EN adds StallCycles / MduCycles counters.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemToRegE,
  input  logic       MemToRegM,
  input  logic       BranchD,
  input  logic       MduStartE,
  input  logic       MduDivE,
  input  logic       HiLoReadD,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushE,
  output logic       FlushW,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MduStep,
  output logic       MduBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] MduCycles
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MDU still iterating; only consulted while in MEM_WAIT, where the FSM
  // state alone cannot tell whether an operation is in flight.
  logic               run_q, run_d;

  logic mem_stall, lw_stall, br_stall, hl_stall, data_stall, mdu_stall;
  logic mdu_running, mdu_accept;

  forward_unit u_forward (
    .rs_d_i        (RsD),
    .rt_d_i        (RtD),
    .rs_e_i        (RsE),
    .rt_e_i        (RtE),
    .write_reg_m_i (WriteRegM),
    .write_reg_w_i (WriteRegW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_a_d_o     (ForwardAD),
    .fwd_b_d_o     (ForwardBD),
    .fwd_a_e_o     (ForwardAE),
    .fwd_b_e_o     (ForwardBE)
  );

  always_comb begin
    mdu_running = (state_q == MDU_RUN) || ((state_q == MEM_WAIT) && run_q);
    mem_stall   = MemReqM && !MemReadyM;

    lw_stall = MemToRegE && ((RtE == RsD) || (RtE == RtD));
    br_stall = BranchD &&
               (reg_hit(RegWriteE, WriteRegE, RsD) || reg_hit(RegWriteE, WriteRegE, RtD) ||
                reg_hit(MemToRegM, WriteRegM, RsD) || reg_hit(MemToRegM, WriteRegM, RtD));
    hl_stall = HiLoReadD && (mdu_running || MduStartE);
    data_stall = lw_stall || br_stall || hl_stall;

    // A second mult/div waits in Execute until the unit drains.
    mdu_stall  = MduStartE && mdu_running;
    // While memory stalls Execute the issuing instruction is re-presented
    // later, so a start is only accepted when the pipe is moving.
    mdu_accept = MduStartE && !mdu_running && !mem_stall;
  end

  always_comb begin
    StallE  = mem_stall || mdu_stall;
    StallM  = mem_stall;
    FlushW  = mem_stall;
    StallF  = StallE || data_stall;
    StallD  = StallE || data_stall;
    FlushE  = data_stall && !StallE;
    MduStep = mdu_running || mdu_accept;
    MduBusy = mdu_running;
  end

  always_comb begin
    cnt_d   = cnt_q;
    run_d   = 1'b0;
    state_d = IDLE;

    if (mdu_accept) begin
      cnt_d = MduDivE ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
      run_d = 1'b1;
    end else if (mdu_running) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
        run_d = 1'b1;
      end
    end

    if (mem_stall)  state_d = MEM_WAIT;
    else if (run_d) state_d = MDU_RUN;
    else            state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cyc_q, mdu_cyc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cyc_q <= '0;
      mdu_cyc_q   <= '0;
    end else begin
      if (StallF)  stall_cyc_q <= stall_cyc_q + 32'd1;
      if (MduBusy) mdu_cyc_q   <= mdu_cyc_q + 32'd1;
    end
  end

  assign StallCycles = stall_cyc_q;
  assign MduCycles   = mdu_cyc_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  localparam int MULT = 32;
  localparam int DIV  = 33;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic       BranchD, MduStartE, MduDivE, HiLoReadD, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic       ForwardAD, ForwardBD, MduStep, MduBusy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, MduCycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: MDU modelled as number of busy cycles still to come.
  int          rem = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_mdu = '0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .BranchD(BranchD),
    .MduStartE(MduStartE), .MduDivE(MduDivE), .HiLoReadD(HiLoReadD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MduStep(MduStep), .MduBusy(MduBusy)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(StallCycles), .MduCycles(MduCycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] src);
    return we && (wr != 0) && (wr == src);
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] src);
    if (hit(RegWriteM, WriteRegM, src)) return 2'd2;
    if (hit(RegWriteW, WriteRegW, src)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic quiet();
    reset = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemToRegE = 0; MemToRegM = 0;
    BranchD = 0; MduStartE = 0; MduDivE = 0; HiLoReadD = 0; MemReqM = 0; MemReadyM = 1;
  endtask

  // One clock: check every output against the model, then advance the model.
  task automatic cyc();
    logic busy, mem, lw, br, hl, dstall, e_stall_e, e_stall_f;
    @(negedge clk);
    busy = (rem > 0);
    mem  = MemReqM && !MemReadyM;
    lw   = MemToRegE && ((RtE == RsD) || (RtE == RtD));
    br   = BranchD && (hit(RegWriteE, WriteRegE, RsD) || hit(RegWriteE, WriteRegE, RtD) ||
                       hit(MemToRegM, WriteRegM, RsD) || hit(MemToRegM, WriteRegM, RtD));
    hl   = HiLoReadD && (busy || MduStartE);
    dstall    = lw || br || hl;
    e_stall_e = mem || (MduStartE && busy);
    e_stall_f = e_stall_e || dstall;
    if (!reset) begin
      check("StallF", StallF, e_stall_f);
      check("StallD", StallD, e_stall_f);
      check("StallE", StallE, e_stall_e);
      check("StallM", StallM, mem);
      check("FlushE", FlushE, dstall && !e_stall_e);
      check("FlushW", FlushW, mem);
      check("ForwardAE", ForwardAE, fwd(RsE));
      check("ForwardBE", ForwardBE, fwd(RtE));
      check("ForwardAD", ForwardAD, hit(RegWriteM, WriteRegM, RsD));
      check("ForwardBD", ForwardBD, hit(RegWriteM, WriteRegM, RtD));
      check("MduBusy", MduBusy, busy);
      check("MduStep", MduStep, busy || (MduStartE && !mem));
`ifdef HAZARD_PERF_CNT_EN
      check("StallCycles", StallCycles, m_stall);
      check("MduCycles", MduCycles, m_mdu);
`endif
    end
    @(posedge clk);
    #1;
    if (reset) begin
      rem = 0; m_stall = '0; m_mdu = '0;
    end else begin
      m_stall = m_stall + {31'd0, e_stall_f};
      m_mdu   = m_mdu + {31'd0, busy};
      if (busy) rem = rem - 1;
      else if (MduStartE && !mem) rem = MduDivE ? DIV : MULT;
    end
  endtask

  task automatic rnd();
    reset     = ($urandom_range(0, 199) == 0);
    RsD       = 5'($urandom_range(0, 3));
    RtD       = 5'($urandom_range(0, 3));
    RsE       = 5'($urandom_range(0, 3));
    RtE       = 5'($urandom_range(0, 3));
    WriteRegE = 5'($urandom_range(0, 3));
    WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    RegWriteE = 1'($urandom);
    RegWriteM = 1'($urandom);
    RegWriteW = 1'($urandom);
    MemToRegE = ($urandom_range(0, 3) == 0);
    MemToRegM = ($urandom_range(0, 3) == 0);
    BranchD   = ($urandom_range(0, 3) == 0);
    MduStartE = ($urandom_range(0, 15) == 0);
    MduDivE   = 1'($urandom);
    HiLoReadD = ($urandom_range(0, 7) == 0);
    MemReqM   = ($urandom_range(0, 3) == 0);
    MemReadyM = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int n;
    quiet();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    #1;
    check("rst_busy", MduBusy, 1'b0);
    check("rst_stallF", StallF, 1'b0);
    check("rst_step", MduStep, 1'b0);
    cyc();

    // Forwarding: writer of $3 in M, then only in W, then $0.
    RsE = 3; WriteRegM = 3; RegWriteM = 1; #1;
    check("fwd_mem", ForwardAE, 2'b10);
    cyc();
    RegWriteM = 0; WriteRegW = 3; RegWriteW = 1; #1;
    check("fwd_wb", ForwardAE, 2'b01);
    cyc();
    RsE = 0; WriteRegW = 0; #1;
    check("fwd_zero", ForwardAE, 2'b00);
    cyc();
    quiet();

    // Load-use: lw $2 in E, consumer of $2 in D; then load moved to W.
    MemToRegE = 1; RegWriteE = 1; WriteRegE = 2; RtE = 2; RsD = 2; #1;
    check("lw_stall", StallD, 1'b1);
    check("lw_flush", FlushE, 1'b1);
    cyc();
    quiet(); WriteRegW = 2; RegWriteW = 1; RsE = 2; #1;
    check("lw_fwd", ForwardAE, 2'b01);
    cyc();
    quiet();

    // Branch on $5 written in E, then writer in M.
    BranchD = 1; RsD = 5; RegWriteE = 1; WriteRegE = 5; #1;
    check("br_stall", StallD, 1'b1);
    cyc();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 5; #1;
    check("br_fwd", ForwardAD, 1'b1);
    check("br_nostall", StallD, 1'b0);
    cyc();
    quiet();

    // Divide followed by mfhi.
    MduStartE = 1; MduDivE = 1; #1;
    check("div_step", MduStep, 1'b1);
    cyc();
    quiet(); HiLoReadD = 1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!MduBusy) break;
      n++;
      cyc();
    end
    check("div_busy_cycles", n, DIV);
    check("mfhi_go", StallD, 1'b0);
    cyc();
    quiet();

    // Multiply with a 3-cycle memory wait in the middle.
    MduStartE = 1; MduDivE = 0;
    cyc();
    quiet();
    cyc(); cyc();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_stallM", StallM, 1'b1);
      check("mw_flushW", FlushW, 1'b1);
      check("mw_step", MduStep, 1'b1);
      cyc();
    end
    MemReadyM = 1; #1;
    check("mw_ready", StallF, 1'b0);
    cyc();
    quiet();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!MduBusy) break;
      n++;
      cyc();
    end
    check("mult_remaining", n, MULT - 6);
    cyc();

    // Reset during a multiply with counter at 10.
    MduStartE = 1; MduDivE = 0;
    cyc();
    quiet();
    for (int i = 0; i < 21; i++) cyc();
    reset = 1;
    cyc();
    reset = 0; #1;
    check("rstmid_busy", MduBusy, 1'b0);
    check("rstmid_stallF", StallF, 1'b0);
    check("rstmid_stallE", StallE, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("rstmid_perf", MduCycles, 32'd0);
`endif
    cyc();

    for (int i = 0; i < 4000; i++) begin
      rnd();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
